// File: rtl/updi_pkg.sv
// Shared types for the UPDI receive path: parity modes and receive frame states.
package updi_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10
    } parity_mode_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/updi_rx_frame_if.sv
// Bit-stream input and word/status output bundle of the UPDI frame receiver.
interface updi_rx_frame_if #(
    parameter int DATA_BITS = 8
) ();
    // Raw two-bit mode: 2'b11 is legal on the wire and behaves as even.
    logic [1:0]           parity_mode;
    logic                 bit_valid;
    logic                 bit_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output parity_mode, bit_valid, bit_in,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  parity_mode, bit_valid, bit_in,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/parity.sv
// Combinational parity of a word; PARITY selects the "even" or "odd" bit to send.
module parity #(
    parameter int    BITS   = 8,
    parameter string PARITY = "even"
) (
    input  logic [BITS-1:0] data,
    output logic            par
);
    // Even parity bit makes the total count of ones even.
    generate
        if (PARITY == "odd") begin : g_odd
            assign par = ~(^data);
        end else begin : g_even
            assign par = ^data;
        end
    endgenerate
endmodule

// File: rtl/updi_rx_frame.sv
// UPDI receive frame assembler: start, LSB-first data, optional parity, stop bits.
module updi_rx_frame
    import updi_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2
) (
    input  logic           clk,
    input  logic           rst,
    updi_rx_frame_if.slave rx
);
    localparam int             CW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    rx_state_t            state, state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [CW-1:0]        cnt;
    logic [1:0]           mode;
    logic                 perr_acc;

    logic [DATA_BITS-1:0] dout_q;
    logic                 dv_q, perr_q, ferr_q;

    logic even_par, exp_par, has_par;
    logic start, shift, last_data, chk_par, stop_bit, done, busy_c;

    // Parity is taken over the fully assembled word once the data phase ends.
    parity #(.BITS(DATA_BITS), .PARITY("even")) u_parity (
        .data (shreg),
        .par  (even_par)
    );

    assign has_par = (mode != PARITY_NONE);
    assign exp_par = even_par ^ (mode == PARITY_ODD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (rx.bit_valid) begin
            case (state)
                RX_IDLE:   if (!rx.bit_in) state_nxt = RX_DATA;
                RX_DATA:   if (cnt == LAST_DATA) state_nxt = has_par ? RX_PARITY : RX_STOP;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP:   if (!rx.bit_in || cnt == LAST_STOP) state_nxt = RX_IDLE;
                default:   state_nxt = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        start     = rx.bit_valid && (state == RX_IDLE) && !rx.bit_in;
        shift     = rx.bit_valid && (state == RX_DATA);
        last_data = shift && (cnt == LAST_DATA);
        chk_par   = rx.bit_valid && (state == RX_PARITY);
        stop_bit  = rx.bit_valid && (state == RX_STOP);
        // A zero stop bit ends the frame at once instead of waiting out the rest.
        done      = stop_bit && (!rx.bit_in || cnt == LAST_STOP);
        busy_c    = (state != RX_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg    <= '0;
            cnt      <= '0;
            mode     <= 2'b00;
            perr_acc <= 1'b0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            dv_q <= done;
            if (start) begin
                mode     <= rx.parity_mode;
                shreg    <= '0;
                cnt      <= '0;
                perr_acc <= 1'b0;
            end
            if (shift) begin
                shreg <= {rx.bit_in, shreg[DATA_BITS-1:1]};
                cnt   <= last_data ? '0 : cnt + CW'(1);
            end
            if (chk_par) begin
                perr_acc <= (rx.bit_in != exp_par);
                cnt      <= '0;
            end
            if (stop_bit) cnt <= cnt + CW'(1);
            if (done) begin
                dout_q <= shreg;
                perr_q <= perr_acc;
                ferr_q <= !rx.bit_in;
            end
        end
    end

    assign rx.data_out   = dout_q;
    assign rx.data_valid = dv_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.busy       = busy_c;

endmodule

// File: tb/tb_updi_rx_frame.sv
// Randomised frame-level bench for updi_rx_frame against a word-level reference model.
module tb_updi_rx_frame;
    import updi_pkg::*;

    localparam int DB = 8;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    updi_rx_frame_if #(.DATA_BITS(DB)) rx ();

    updi_rx_frame #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx)
    );

    int   total = 0;
    int   bad   = 0;
    int   npulse = 0;
    int   nstr  = 0;
    int   exp_pulses = 0;
    logic dv_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every data_valid pulse must be single-cycle and coincide with busy low.
    always @(negedge clk) begin
        if (rx.data_valid === 1'b1) begin
            npulse <= npulse + 1;
            chk("dv_width", {31'd0, dv_prev}, 0);
            chk("busy_at_dv", {31'd0, rx.busy}, 0);
        end
        dv_prev <= rx.data_valid;
    end

    task automatic idle(input int n);
        repeat (n) begin
            rx.bit_valid = 1'b0;
            rx.bit_in    = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_bit(input logic b, input int gapmax);
        if (gapmax > 0) idle($urandom_range(0, gapmax));
        rx.bit_valid = 1'b1;
        rx.bit_in    = b;
        nstr++;
        @(posedge clk); #1;
        rx.bit_valid = 1'b0;
    endtask

    // Reference: expected status is derived from the word, mode and line bits sent.
    task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] m, input logic flip,
                              input logic s0, input logic s1, input int gapmax, input logic scramble);
        logic pbit, e_perr, e_ferr;
        int   ones;
        ones = $countones(d);
        rx.parity_mode = m;
        send_bit(1'b0, gapmax);
        chk("busy_rise", {31'd0, rx.busy}, 1);
        if (scramble) rx.parity_mode = 2'($urandom);
        for (int i = 0; i < DB; i++) send_bit(d[i], gapmax);
        e_perr = 1'b0;
        if (m != 2'b00) begin
            pbit   = ((ones % 2) == 1) ^ (m == 2'b10);
            send_bit(pbit ^ flip, gapmax);
            e_perr = flip;
        end
        send_bit(s0, gapmax);
        if (s0 && SB == 2) send_bit(s1, gapmax);
        e_ferr = !s0 || (SB == 2 && !s1);
        exp_pulses++;
        chk("dv", {31'd0, rx.data_valid}, 1);
        chk("data", {24'd0, rx.data_out}, {24'd0, d});
        chk("perr", {31'd0, rx.parity_err}, {31'd0, e_perr});
        chk("ferr", {31'd0, rx.frame_err}, {31'd0, e_ferr});
        chk("busy_fall", {31'd0, rx.busy}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, s0n;
        rst            = 1'b1;
        rx.bit_valid   = 1'b0;
        rx.bit_in      = 1'b1;
        rx.parity_mode = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, rx.data_out}, 0);
        chk("rst_dv", {31'd0, rx.data_valid}, 0);
        chk("rst_perr", {31'd0, rx.parity_err}, 0);
        chk("rst_ferr", {31'd0, rx.frame_err}, 0);
        chk("rst_busy", {31'd0, rx.busy}, 0);
        rst = 1'b0;
        idle(3);

        // Directed frames
        send_frame(8'h55, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        send_frame(8'h07, 2'b01, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        send_frame(8'h00, 2'b10, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        s0n = nstr;
        send_frame(8'hA3, 2'b00, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        chk("strobes_none", nstr - s0n, 11);
        idle(2);
        send_frame(8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        send_frame(8'h81, 2'b11, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        idle(2);
        chk("pulses_directed", npulse, exp_pulses);

        // Reset after four data bits drops the partial frame
        send_frame(8'hA5, 2'b01, 1'b1, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        p0 = npulse;
        rx.parity_mode = 2'b01;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, rx.data_out}, 0);
        chk("mid_rst_perr", {31'd0, rx.parity_err}, 0);
        chk("mid_rst_busy", {31'd0, rx.busy}, 0);
        chk("mid_rst_dv", {31'd0, rx.data_valid}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(3);
        chk("mid_rst_nopulse", npulse, p0);
        send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(2);

        // Back-to-back, then with random gaps
        p0 = npulse;
        send_frame(8'h12, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        send_frame(8'hFE, 2'b01, 1'b0, 1'b1, 1'b1, 0, 1'b0);
        idle(2);
        chk("b2b_pulses", npulse - p0, 2);
        p0 = npulse;
        send_frame(8'h12, 2'b01, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        send_frame(8'hFE, 2'b01, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        idle(2);
        chk("gap_pulses", npulse - p0, 2);

        // Random frames, mode scrambled mid-frame
        for (int k = 0; k < 40; k++) begin
            send_frame(8'($urandom), 2'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                       $urandom_range(0, 3), 1'b1);
        end
        idle(3);
        chk("pulses_total", npulse, exp_pulses);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/updi_rx_frame.md
# updi_rx_frame

Serial frame assembler and checker for the UPDI receive path. It sits after the bit sampler, takes one sampled line bit per `bit_valid` strobe, and assembles start, data, optional parity and stop bits into a data word. It checks parity in a mode selected per frame at run time and reports parity and framing errors alongside each completed word. It replaces compile-time-only parity generation with a runtime-selectable, width-parametrised receive checker.

## Interface
- `DATA_BITS`, default 8: data bits per frame, sent LSB first. Legal range 5..9.
- `STOP_BITS`, default 2: stop bits expected per frame. Legal values 1..2.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as even. Sampled only on the start-bit strobe.
- `bit_valid`  in  1  one-cycle strobe: `bit_in` holds a sampled line bit this cycle.
- `bit_in`  in  1  sampled line level.
- `data_out`  out  DATA_BITS  assembled word.
- `data_valid`  out  1  one-cycle pulse: frame complete.
- `parity_err`  out  1  parity mismatch in the last completed frame.
- `frame_err`  out  1  a stop bit was 0 in the last completed frame.
- `busy`  out  1  high while a frame is in progress (state not IDLE).

## Operation
- States: IDLE, DATA, PARITY, STOP.
- Every transition below happens only on a cycle where `bit_valid`=1. With `bit_valid`=0, state and datapath hold.
- IDLE:
  - `bit_in`=1 is line idle and is ignored.
  - `bit_in`=0 is the start bit: latch `parity_mode`, clear the shift register, bit counter and error accumulators, then go to DATA.
- DATA:
  - Shift `bit_in` into the MSB of the shift register (right shift), so bit 0 of the word is received first.
  - Increment the counter.
  - After the DATA_BITS-th bit, go to PARITY if the latched mode is not none; otherwise go to STOP.
- PARITY:
  - Expected bit = XOR of all data bits (even, and 11), or its inverse (odd).
  - On mismatch, set the internal parity error bit.
  - Go to STOP and reset the counter.
- STOP:
  - Each stop bit must be 1.
  - On the first 0 stop bit, set the frame error and complete the frame immediately; remaining stop bits are not awaited.
  - Otherwise complete after the STOP_BITS-th stop bit.
- Completion:
  - Register `data_out`, `parity_err` and `frame_err`.
  - Pulse `data_valid`.
  - Return to IDLE.
- Outputs hold their values until the next completion.
- A `parity_mode` change mid-frame has no effect until the next start bit.
- No backpressure: the consumer must take the word on the `data_valid` pulse.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0, state IDLE.
- `data_valid` rises in the cycle after the clock edge that captures the completing stop-bit strobe, and lasts exactly one cycle.
- `data_out`, `parity_err` and `frame_err` change in that same cycle.
- `busy` rises the cycle after the start-bit strobe. It falls in the same cycle `data_valid` rises.
- The state is already IDLE when `data_valid` is high. A start bit strobed during the `data_valid` cycle is accepted, so back-to-back frames have zero gap.
- `bit_valid` may arrive on consecutive cycles or with arbitrary gaps. Behaviour is identical in both cases.
- Reset asserted mid-frame:
  - The partial frame is discarded and no `data_valid` is produced.
  - All outputs take their reset values immediately (asynchronous).
- Frame length in strobes: 1 + DATA_BITS + (parity ? 1 : 0) + STOP_BITS. The UPDI default, 8E2, is 12 strobes.

## Structure
- Shared package `updi_pkg`:
  - `parity_mode_t` enum: PARITY_NONE=2'b00, PARITY_EVEN=2'b01, PARITY_ODD=2'b10.
  - `rx_state_t` enum for the four states.
- Bit counter width: $clog2(DATA_BITS+1).
- Sub-module: instantiate the team's `parity` module with BITS=DATA_BITS and PARITY="even" on the assembled shift register. Odd parity is its inverse. No serial XOR accumulator is needed.
- The state register, shift register, counter and output registers all live in this module.

## Test plan
- 8E2, strobes 0,1,0,1,0,1,0,1,0,0,1,1 (data 0x55, parity 0) -> one `data_valid` pulse, `data_out`=0x55, `parity_err`=0, `frame_err`=0.
- Even mode, data 0x07 with parity bit 0 (expected 1) -> `data_out`=0x07, `parity_err`=1. Odd mode, data 0x00 with parity bit 1 -> `parity_err`=0.
- Mode none, data 0xA3 followed directly by stops 1,1 -> `data_out`=0xA3 after 11 strobes, no errors.
- 8E2, data 0x3C, correct parity, first stop bit 0 -> `data_valid` on the cycle after that stop strobe, `frame_err`=1, `busy`=0. The next start bit is accepted normally.
- Reset asserted after 4 data bits -> no pulse, all outputs 0. The following frame 0x3C is then received cleanly.
- Two 8E2 frames, 0x12 then 0xFE, strobed every cycle with the second start bit in the `data_valid` cycle; repeat with random 0..5-cycle gaps between strobes -> two pulses in both runs, correct data, no errors.
